// File: rtl/motion_frame_scheduler.sv
// Frame-level sequencer for the motion detector: scans every pixel address,
// pipes reads through the detector, writes the motion mask and raises a frame alarm.
module motion_frame_scheduler #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 48,
  parameter int ADDR_W  = 12,
  parameter int CNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        threshold_cfg,
  input  logic [CNT_W-1:0]  alarm_min_cnt,
  input  logic              mem_stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              det_enable,
  output logic [7:0]        det_threshold,
  input  logic              det_motion,
  output logic              mask_wr_en,
  output logic [ADDR_W-1:0] mask_addr,
  output logic              mask_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  motion_count,
  output logic              frame_alarm,
  output logic [1:0]        fsm_state
);

  localparam int unsigned          NPIX      = FRAME_W * FRAME_H;
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0]    ADDR_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Handshake: mem_rd_en/mem_addr form a valid-only strobe (no ready), the store
  // answers one cycle later; mem_stall only gates issue, it never back-pressures
  // reads already in flight. det_enable and mask_wr_en are valid-only strobes.

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] s1_addr;
  logic [CNT_W-1:0]  min_cnt;
  logic [CNT_W-1:0]  count_next;

  assign fsm_state = state;
  assign busy      = (state == S_SCAN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  // The detector result arrives in the same cycle as the mask write strobe.
  assign mask_data = mask_wr_en & det_motion;

  always_comb begin
    count_next = motion_count;
    if (mask_wr_en && det_motion && (motion_count != '1)) begin
      count_next = motion_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      addr_cnt      <= '0;
      s1_addr       <= '0;
      min_cnt       <= '0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      det_enable    <= 1'b0;
      det_threshold <= '0;
      mask_wr_en    <= 1'b0;
      mask_addr     <= '0;
      motion_count  <= '0;
      frame_alarm   <= 1'b0;
    end else begin
      det_enable   <= mem_rd_en;
      s1_addr      <= mem_addr;
      mask_wr_en   <= det_enable;
      mask_addr    <= s1_addr;
      motion_count <= count_next;
      mem_rd_en    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            det_threshold <= threshold_cfg;
            min_cnt       <= alarm_min_cnt;
            motion_count  <= '0;
            addr_cnt      <= '0;
            state         <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!mem_stall) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_cnt;
            if (addr_cnt == LAST_ADDR) begin
              state <= S_DRAIN;
            end else begin
              addr_cnt <= addr_cnt + ADDR_ONE;
            end
          end
        end
        S_DRAIN: begin
          // With no read and no detector strobe this cycle, the last mask write
          // retires on this edge, so the alarm is judged on the final count.
          if (!mem_rd_en && !det_enable) begin
            state       <= S_DONE;
            frame_alarm <= (count_next >= min_cnt);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_frame_scheduler.sv
// Bench for motion_frame_scheduler on a 4x2 frame: randomized frames against a
// frame-level reference (ordered mask writes, saturated count, alarm, latencies).
module tb_motion_frame_scheduler;

  localparam int FW   = 4;
  localparam int FH   = 2;
  localparam int AW   = 3;
  localparam int CW   = 3;
  localparam int NPIX = FW * FH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    threshold_cfg = '0;
  logic [CW-1:0] alarm_min_cnt = '0;
  logic          mem_stall = 1'b0;
  logic          det_motion = 1'b0;
  logic          mem_rd_en, det_enable, mask_wr_en, mask_data, busy, done, frame_alarm;
  logic [AW-1:0] mem_addr, mask_addr;
  logic [7:0]    det_threshold;
  logic [CW-1:0] motion_count;
  logic [1:0]    fsm_state;

  motion_frame_scheduler #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .threshold_cfg(threshold_cfg),
    .alarm_min_cnt(alarm_min_cnt), .mem_stall(mem_stall), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .det_enable(det_enable), .det_threshold(det_threshold),
    .det_motion(det_motion), .mask_wr_en(mask_wr_en), .mask_addr(mask_addr),
    .mask_data(mask_data), .busy(busy), .done(done), .motion_count(motion_count),
    .frame_alarm(frame_alarm), .fsm_state(fsm_state)
  );

  // clock / cycle counter
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // store + detector responder: data one cycle after the read, result one cycle later
  logic [NPIX-1:0] motion_map = '0;
  logic            rd_data = 1'b0;
  always @(posedge clk) begin
    rd_data    <= mem_rd_en ? motion_map[mem_addr] : 1'b0;
    det_motion <= det_enable ? rd_data : 1'b0;
  end

  // scoreboard state
  logic [AW:0]   exp_q[$];
  int            rd_times[$];
  int            total = 0, bad = 0;
  int            exp_rd_addr, rd_seen, done_seen, last_rd, start_cyc, exp_len;
  logic [7:0]    cur_thr;
  logic [CW-1:0] exp_cnt;
  logic          exp_alarm;
  bit            mon_on = 1'b0;
  logic [AW:0]   e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({mem_rd_en, mem_addr, det_enable, det_threshold, mask_wr_en, mask_addr,
                    mask_data, busy, done, motion_count, frame_alarm}), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_rd_en) begin
        check("rd_addr", 32'(mem_addr), 32'(exp_rd_addr));
        rd_times.push_back(cyc);
        last_rd = cyc;
        exp_rd_addr++;
        rd_seen++;
      end
      if (mask_wr_en) begin
        if (exp_q.size() == 0) begin
          check("extra_wr", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mask_addr), 32'(e[AW:1]));
          check("wr_data", 32'(mask_data), 32'(e[0]));
          if (rd_times.size() == 0) check("wr_before_rd", 32'd1, 32'd0);
          else check("wr_lat", 32'(cyc - rd_times.pop_front()), 32'd2);
        end
      end
      if (busy) check("thr", 32'(det_threshold), 32'(cur_thr));
      if (done) begin
        done_seen++;
        check("count", 32'(motion_count), 32'(exp_cnt));
        check("alarm", 32'(frame_alarm), 32'(exp_alarm));
        check("done_lat", 32'(cyc - last_rd), 32'd3);
        if (exp_len > 0) check("frame_len", 32'(cyc - start_cyc), 32'(exp_len));
      end
    end
  end

  // builds the frame-level expectation, then starts the frame
  task automatic setup_frame(input logic [7:0] thr, input logic [CW-1:0] mn,
                             input logic [NPIX-1:0] map, input int mode);
    int ones;
    ones = $countones(map);
    if (ones > (1 << CW) - 1) exp_cnt = '1;
    else exp_cnt = ones[CW-1:0];
    exp_alarm = (exp_cnt >= mn);
    exp_q.delete();
    rd_times.delete();
    for (int a = 0; a < NPIX; a++) exp_q.push_back({AW'(a), map[a]});
    exp_rd_addr = 0;
    rd_seen     = 0;
    motion_map  = map;
    cur_thr     = thr;
    exp_len     = (mode == 0) ? NPIX + 4 : (mode == 1) ? NPIX + 7 : 0;
    @(negedge clk); #1;
    start         = 1'b1;
    threshold_cfg = thr;
    alarm_min_cnt = mn;
    start_cyc     = cyc;
  endtask

  // mode 0: no stall, 1: stall on scan cycles 2-4, 2: random stall
  task automatic run_frame(input logic [7:0] thr, input logic [CW-1:0] mn,
                           input logic [NPIX-1:0] map, input int mode, input bit poke);
    int  d0;
    bit  got;
    d0  = done_seen;
    got = 1'b0;
    setup_frame(thr, mn, map, mode);
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk); #1;
      start = 1'b0;
      case (mode)
        1:       mem_stall = (k >= 2 && k <= 4);
        2:       mem_stall = ($urandom_range(0, 3) == 0);
        default: mem_stall = 1'b0;
      endcase
      if (poke) begin
        if (k == 3 || k == 7) start = 1'b1;
        if (k == 5) threshold_cfg = 8'd200;
        if (k == 6) alarm_min_cnt = '0;
      end
      if (done_seen != d0) begin
        got = 1'b1;
        if (poke) start = 1'b1;
      end
    end
    check("frame_done", 32'(got), 32'd1);
    check("done_once", 32'(done_seen - d0), 32'd1);
    check("wr_left", 32'(exp_q.size()), 32'd0);
    if (poke) begin
      @(negedge clk); #1;
      start = 1'b0;
      check("no_restart", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      check("done_once_late", 32'(done_seen - d0), 32'd1);
    end
  endtask

  task automatic reset_in_drain(input logic [NPIX-1:0] map);
    bit hit;
    hit = 1'b0;
    setup_frame(8'd33, 3'd1, map, 0);
    for (int k = 1; k <= 100 && !hit; k++) begin
      @(negedge clk); #1;
      start = 1'b0;
      mem_stall = 1'b0;
      if (rd_seen == NPIX) hit = 1'b1;
    end
    check("reached_drain", 32'(hit), 32'd1);
    mon_on = 1'b0;
    rst    = 1'b0;
    start  = 1'b1;
    @(negedge clk); #1;
    check_zero("rst_drain_outs");
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check("post_rst_wr", 32'(mask_wr_en), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    mon_on = 1'b1;
  endtask

  initial begin
    done_seen = 0;
    rd_seen   = 0;
    exp_len   = 0;
    start     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset_outs");
    rst    = 1'b1;
    start  = 1'b0;
    mon_on = 1'b1;
    @(negedge clk);

    run_frame(8'd10, 3'd3, 8'b0100_1010, 0, 1'b0);
    run_frame(8'd10, 3'd4, 8'b0100_1010, 0, 1'b0);
    run_frame(8'd10, 3'd3, 8'b0100_1010, 1, 1'b0);
    run_frame(8'd10, 3'd4, 8'b0100_1010, 0, 1'b1);
    run_frame(8'd77, 3'd7, 8'hFF, 0, 1'b0);
    run_frame(8'd5, 3'd0, 8'h00, 0, 1'b0);
    reset_in_drain(8'b1011_0001);
    run_frame(8'd42, 3'd2, 8'b0011_0110, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_frame(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                8'($urandom), 2, 1'b0);
    end

    mem_stall = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
